// File: rtl/ir_pkg.sv
// NEC IR shared definitions: FSM encoding, request payload and timing constants
// common to the transmit and receive stages.
package ir_pkg;

  localparam int unsigned DATA_W            = 32;
  localparam int unsigned DEF_CLK_DIV       = 50;
  localparam int unsigned NEC_LEAD_MARK_US  = 9000;
  localparam int unsigned NEC_LEAD_SPACE_US = 4500;
  localparam int unsigned NEC_REP_SPACE_US  = 2250;
  localparam int unsigned NEC_BIT_MARK_US   = 560;
  localparam int unsigned NEC_ZERO_SPACE_US = 560;
  localparam int unsigned NEC_ONE_SPACE_US  = 1690;
  localparam int unsigned NEC_GAP_US        = 40000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_MARK,
    ST_LEAD_SPACE,
    ST_BIT_MARK,
    ST_BIT_SPACE,
    ST_STOP_MARK,
    ST_GAP
  } ir_state_e;

  typedef struct packed {
    logic              rep;
    logic [DATA_W-1:0] data;
  } ir_req_t;

  // Carrier-on segments pull the inverted line low
  function automatic logic is_mark(input ir_state_e s);
    return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_tx_if.sv
// Request/status handshake between a frame source and the NEC transmitter.
interface ir_tx_if;
  import ir_pkg::*;

  logic              i_start;
  logic              i_repeat;
  logic [DATA_W-1:0] i_data;
  logic              o_busy;
  logic              o_done;

  modport master (output i_start, output i_repeat, output i_data,
                  input  o_busy,  input  o_done);
  modport slave  (input  i_start, input  i_repeat, input  i_data,
                  output o_busy,  output o_done);
endinterface

// File: rtl/ir_tick_gen.sv
// 1 us clock-enable generator; clr restarts the prescaler so segments start phase-aligned.
module ir_tick_gen
  import ir_pkg::*;
#(
  parameter int unsigned DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ir_tx.sv
// NEC IR frame transmitter: lead code, 32 pulse-distance bits MSB first, stop mark
// and inter-frame gap, or a repeat frame; drives the inverted (active-low) IR line.
module ir_tx
  import ir_pkg::*;
#(
  parameter int unsigned CLK_DIV       = DEF_CLK_DIV,
  parameter int unsigned LEAD_MARK_US  = NEC_LEAD_MARK_US,
  parameter int unsigned LEAD_SPACE_US = NEC_LEAD_SPACE_US,
  parameter int unsigned REP_SPACE_US  = NEC_REP_SPACE_US,
  parameter int unsigned BIT_MARK_US   = NEC_BIT_MARK_US,
  parameter int unsigned ZERO_SPACE_US = NEC_ZERO_SPACE_US,
  parameter int unsigned ONE_SPACE_US  = NEC_ONE_SPACE_US,
  parameter int unsigned GAP_US        = NEC_GAP_US
) (
  input  logic   clk,
  input  logic   rst_n,
  ir_tx_if.slave bus,
  output logic   o_ir_txb
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 5;

  ir_state_e        state, state_nxt;
  logic [CNT_W-1:0] seg_cnt, gap_cnt, seg_len_c;
  logic [IDX_W-1:0] bit_idx;
  ir_req_t          req_q;
  logic             tick_c, accept_c, seg_state_c, seg_end_c, gap_end_c, clr_c;
  logic             txb_nxt, busy_nxt, done_nxt;

  assign accept_c    = (state == ST_IDLE) && bus.i_start;
  assign seg_state_c = (state == ST_LEAD_MARK) || (state == ST_LEAD_SPACE) ||
                       (state == ST_BIT_MARK)  || (state == ST_BIT_SPACE)  ||
                       (state == ST_STOP_MARK);

  // Length in us ticks of the segment currently on the line
  always_comb begin
    seg_len_c = '0;
    case (state)
      ST_LEAD_MARK:  seg_len_c = CNT_W'(LEAD_MARK_US);
      ST_LEAD_SPACE: seg_len_c = req_q.rep ? CNT_W'(REP_SPACE_US) : CNT_W'(LEAD_SPACE_US);
      ST_BIT_MARK:   seg_len_c = CNT_W'(BIT_MARK_US);
      ST_BIT_SPACE:  seg_len_c = req_q.data[DATA_W-1] ? CNT_W'(ONE_SPACE_US)
                                                      : CNT_W'(ZERO_SPACE_US);
      ST_STOP_MARK:  seg_len_c = CNT_W'(BIT_MARK_US);
      default:       seg_len_c = '0;
    endcase
  end

  assign seg_end_c = seg_state_c && tick_c && (seg_cnt == seg_len_c - CNT_W'(1));
  assign gap_end_c = (state == ST_GAP) && tick_c && (gap_cnt == CNT_W'(GAP_US - 1));
  assign clr_c     = accept_c || seg_end_c || gap_end_c;

  ir_tick_gen #(.DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_c),
    .tick_c (tick_c)
  );

  // State and registered line/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      o_ir_txb   <= 1'b1;
      bus.o_busy <= 1'b0;
      bus.o_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_ir_txb   <= txb_nxt;
      bus.o_busy <= busy_nxt;
      bus.o_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE:       if (bus.i_start) state_nxt = ST_LEAD_MARK;
      ST_LEAD_MARK:  if (seg_end_c)   state_nxt = ST_LEAD_SPACE;
      ST_LEAD_SPACE: if (seg_end_c)   state_nxt = req_q.rep ? ST_STOP_MARK : ST_BIT_MARK;
      ST_BIT_MARK:   if (seg_end_c)   state_nxt = ST_BIT_SPACE;
      ST_BIT_SPACE:  if (seg_end_c)   state_nxt = (bit_idx == IDX_W'(DATA_W - 1))
                                                  ? ST_STOP_MARK : ST_BIT_MARK;
      ST_STOP_MARK:  if (seg_end_c)   state_nxt = ST_GAP;
      ST_GAP: begin
        if (gap_end_c) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default:       state_nxt = ST_IDLE;
    endcase
    txb_nxt  = !is_mark(state_nxt);
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // Segment/gap tick counters and the payload shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_cnt <= '0;
      gap_cnt <= '0;
      bit_idx <= '0;
      req_q   <= '0;
    end else begin
      if (accept_c || seg_end_c) begin
        seg_cnt <= '0;
      end else if (seg_state_c && tick_c) begin
        seg_cnt <= seg_cnt + CNT_W'(1);
      end

      if ((state != ST_GAP) || gap_end_c) begin
        gap_cnt <= '0;
      end else if (tick_c) begin
        gap_cnt <= gap_cnt + CNT_W'(1);
      end

      if (accept_c) begin
        req_q.rep  <= bus.i_repeat;
        req_q.data <= bus.i_data;
        bit_idx    <= '0;
      end else if (seg_end_c && (state == ST_BIT_SPACE)) begin
        req_q.data <= {req_q.data[DATA_W-2:0], 1'b0};
        if (bit_idx != IDX_W'(DATA_W - 1)) begin
          bit_idx <= bit_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/ir_tx.md
Name: ir_tx

Overview:
- NEC-format IR frame transmitter.
- Sits directly upstream of the IR receive stage. It drives the demodulated, inverted IR line (`o_ir_txb`) that the receiver samples on `i_ir_rxb`.
- Used for board-level loopback and self-test of the receive/display path. It also serves as the base of a future modulated IR emitter.
- Generates the lead code, 32 pulse-distance data bits, the stop mark and an inter-frame gap. It can also send an NEC repeat frame.

Parameters:
- CLK_DIV, 50, clk cycles per 1 us tick (50 MHz clk)
- LEAD_MARK_US, 9000, lead mark length
- LEAD_SPACE_US, 4500, lead space length for a data frame
- REP_SPACE_US, 2250, lead space length for a repeat frame
- BIT_MARK_US, 560, mark length per bit and for the stop mark
- ZERO_SPACE_US, 560, space length after a '0' bit
- ONE_SPACE_US, 1690, space length after a '1' bit
- GAP_US, 40000, idle time after the stop mark before the block is free again

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  request to send a frame; level sampled each clk
- i_repeat  in  1  qualifies i_start: 1 = repeat frame, 0 = data frame
- i_data  in  32  frame payload; i_data[31] is sent first
- o_ir_txb  out  1  inverted IR line; 0 = mark (carrier present), 1 = space/idle
- o_busy  out  1  frame in progress, including the gap
- o_done  out  1  one-clk pulse when the gap ends

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low (clk, rst_n).
  - Reset values: o_ir_txb=1, o_busy=0, o_done=0, FSM=IDLE, all counters 0.
  - Reset asserted mid-frame forces o_ir_txb high immediately (asynchronously) and aborts the frame. No o_done is issued.
- Handshake:
  - In IDLE, i_start=1 is accepted on that clk edge. i_data and i_repeat are latched at the same edge.
  - o_busy=1 and o_ir_txb=0 from the next cycle onward.
  - i_start while o_busy=1 is ignored, and nothing is queued.
  - When the gap ends: o_done=1 for exactly one cycle, o_busy falls in the same cycle, and FSM returns to IDLE.
  - A new start is accepted from the cycle after o_done.
- Timing:
  - The us-tick prescaler (0..CLK_DIV-1) is cleared on accept and on every segment change. Each segment therefore lasts exactly N_US*CLK_DIV clk cycles, with no jitter.
  - Segment counter is 16 bits, counting ticks. The gap uses a separate 16-bit count, since 40000 fits.
- FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
  - IDLE -> LEAD_MARK on accept.
  - LEAD_MARK (o_ir_txb=0, LEAD_MARK_US) -> LEAD_SPACE.
  - LEAD_SPACE (1): lasts REP_SPACE_US if repeat, else LEAD_SPACE_US. Then goes to STOP_MARK if repeat, else BIT_MARK with bit index 0.
  - BIT_MARK (0, BIT_MARK_US) -> BIT_SPACE.
  - BIT_SPACE (1): lasts ONE_SPACE_US if shreg[31], else ZERO_SPACE_US. Then shift shreg left by 1 and increment bit index. After index 31 go to STOP_MARK, else go to BIT_MARK.
  - STOP_MARK (0, BIT_MARK_US) -> GAP.
  - GAP (1, GAP_US) -> IDLE with o_done.
- o_ir_txb is a registered output, glitch-free, driven from FSM state only.
- Bit index is 5 bits and must not wrap before STOP_MARK. Exactly 32 data marks plus 1 stop mark are sent per data frame.

Decomposition:
- Shared package/include ir_pkg:
  - FSM state encodings.
  - NEC timing constants (us values listed above).
  - CLK_DIV default.
  - These are shared with the IR receive stage so both sides use identical timings.
- One sub-module, ir_tick_gen: 1 us clock-enable pulse generator with a synchronous clear input.
  - It is a clock-enable, not a derived clock; all logic stays on clk.

Test Plan:
- Reset check: hold rst_n=0, then release -> o_ir_txb=1, o_busy=0, o_done=0. No activity for 1 ms.
- Data frame: i_start=1 for 1 cycle with i_data=32'h00FF30CF, i_repeat=0. Expected response:
  - o_ir_txb low 450000 cycles, then high 225000.
  - Per bit: low 28000, then high 84500 ('1') or 28000 ('0'), MSB first.
  - Stop mark low 28000, then gap.
  - o_busy high for 5399000 cycles (107980 us); o_done pulses once at the end.
- Loopback: connect o_ir_txb to the receiver's i_ir_rxb and send 32'hA55A1EE1 -> receiver output equals 32'hA55A1EE1 after the frame.
- Busy ignore: second i_start with 32'hFFFFFFFF during bit 5 of the first frame. Expected:
  - Waveform is identical to the single-frame case.
  - Only one o_done.
- Repeat frame: i_start with i_repeat=1. Expected:
  - Low 450000, high 112500, low 28000, then gap 2000000.
  - o_busy length 2590500 cycles; o_done once.
- Reset mid-frame: assert rst_n=0 during bit 10. Expected:
  - o_ir_txb=1 in the same cycle (asynchronously); o_busy=0; no o_done.
  - After release, a new start with 32'h12345678 produces a complete, correctly timed frame.
